// File: rtl/phy_rst_seq.sv
// Multi-channel transceiver reset sequencer: one shared TX PLL/TX reset FSM plus a
// per-channel RX FSM with CDR/block-lock qualification, watchdog re-reset and relock counters.
module phy_rst_seq #(
    parameter int NUM_CH       = 1,
    parameter int CNT_W        = 20,
    parameter int T_ANALOG     = 100,
    parameter int T_DIGITAL    = 20,
    parameter int T_LTD        = 400,
    parameter int T_BL_TIMEOUT = 100000
) (
    input  logic                  csr_clk,
    input  logic                  csr_rst_n,
    input  logic                  soft_reset_req,
    input  logic [NUM_CH-1:0]     ch_enable,
    input  logic                  pll_locked,
    input  logic [NUM_CH-1:0]     tx_cal_busy,
    input  logic [NUM_CH-1:0]     rx_cal_busy,
    input  logic [NUM_CH-1:0]     rx_is_lockedtodata,
    input  logic [NUM_CH-1:0]     block_lock,
    output logic                  pll_powerdown,
    output logic [NUM_CH-1:0]     tx_analogreset,
    output logic [NUM_CH-1:0]     tx_digitalreset,
    output logic [NUM_CH-1:0]     rx_analogreset,
    output logic [NUM_CH-1:0]     rx_digitalreset,
    output logic [NUM_CH-1:0]     tx_ready,
    output logic [NUM_CH-1:0]     rx_ready,
    output logic                  phy_ready,
    output logic [8*NUM_CH-1:0]   relock_count
);

    localparam int SYNC_W = 1 + 4 * NUM_CH;
    localparam logic [CNT_W-1:0] T_ANA_LAST = CNT_W'(T_ANALOG - 1);
    localparam logic [CNT_W-1:0] T_DIG_LAST = CNT_W'(T_DIGITAL - 1);
    localparam logic [CNT_W-1:0] T_LTD_LAST = CNT_W'(T_LTD - 1);
    localparam logic [CNT_W-1:0] T_BL_LAST  = CNT_W'(T_BL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [NUM_CH-1:0] ALL_ONES  = {NUM_CH{1'b1}};

    typedef enum logic [1:0] {
        TX_PD    = 2'd0,
        TX_WAIT  = 2'd1,
        TX_DIG   = 2'd2,
        TX_READY = 2'd3
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_ANA   = 3'd0,
        RX_CAL   = 3'd1,
        RX_LTD   = 3'd2,
        RX_BL    = 3'd3,
        RX_READY = 3'd4
    } rx_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        if (val == 8'hFF) begin
            sat_inc8 = val;
        end else begin
            sat_inc8 = val + 8'd1;
        end
    endfunction

    logic [SYNC_W-1:0] async_s;
    logic [SYNC_W-1:0] meta_q;
    logic [SYNC_W-1:0] sync_q;
    logic              pll_s;
    logic [NUM_CH-1:0] tx_cal_s;
    logic [NUM_CH-1:0] rx_cal_s;
    logic [NUM_CH-1:0] ltd_s;
    logic [NUM_CH-1:0] bl_s;
    logic              tx_cond_s;

    tx_state_e         tx_state_q, tx_state_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    rx_state_e         rx_state_q [NUM_CH];
    rx_state_e         rx_state_d [NUM_CH];
    logic [CNT_W-1:0]  rx_cnt_q [NUM_CH];
    logic [CNT_W-1:0]  rx_cnt_d [NUM_CH];
    logic [8*NUM_CH-1:0] relock_q, relock_d;

    logic              pd_q, pd_d;
    logic [NUM_CH-1:0] tx_ana_q, tx_ana_d;
    logic [NUM_CH-1:0] tx_dig_q, tx_dig_d;
    logic [NUM_CH-1:0] rx_ana_q, rx_ana_d;
    logic [NUM_CH-1:0] rx_dig_q, rx_dig_d;
    logic [NUM_CH-1:0] tx_ready_q, tx_ready_d;
    logic [NUM_CH-1:0] rx_ready_q, rx_ready_d;
    logic              phy_ready_q, phy_ready_d;

    assign async_s = {pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata, block_lock};
    assign {pll_s, tx_cal_s, rx_cal_s, ltd_s, bl_s} = sync_q;

    // Two-flop synchronisers for every asynchronous status input.
    always_ff @(posedge csr_clk or negedge csr_rst_n) begin
        if (!csr_rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_s;
            sync_q <= meta_q;
        end
    end

    // Disabled channels never hold up TX digital release.
    assign tx_cond_s = pll_s & (&(~tx_cal_s | ~ch_enable));

    // Shared TX FSM next state; soft reset overrides everything.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        if (soft_reset_req) begin
            tx_state_d = TX_PD;
            tx_cnt_d   = '0;
        end else begin
            case (tx_state_q)
                TX_PD: begin
                    if (tx_cnt_q == T_ANA_LAST) begin
                        tx_state_d = TX_WAIT;
                        tx_cnt_d   = '0;
                    end else begin
                        tx_cnt_d   = tx_cnt_q + CNT_ONE;
                    end
                end
                TX_WAIT: begin
                    tx_cnt_d = '0;
                    if (tx_cond_s) begin
                        tx_state_d = TX_DIG;
                    end else begin
                        tx_state_d = TX_WAIT;
                    end
                end
                TX_DIG: begin
                    if (!tx_cond_s) begin
                        tx_state_d = TX_WAIT;
                        tx_cnt_d   = '0;
                    end else if (tx_cnt_q == T_DIG_LAST) begin
                        tx_state_d = TX_READY;
                        tx_cnt_d   = '0;
                    end else begin
                        tx_cnt_d   = tx_cnt_q + CNT_ONE;
                    end
                end
                TX_READY: begin
                    tx_cnt_d = '0;
                    if (!pll_s) begin
                        tx_state_d = TX_WAIT;
                    end else begin
                        tx_state_d = TX_READY;
                    end
                end
                default: begin
                    tx_state_d = TX_PD;
                    tx_cnt_d   = '0;
                end
            endcase
        end
    end

    // Per-channel RX FSM next state and saturating relock accounting.
    always_comb begin
        relock_d = relock_q;
        for (int i = 0; i < NUM_CH; i++) begin
            rx_state_d[i] = rx_state_q[i];
            rx_cnt_d[i]   = rx_cnt_q[i];
            if (soft_reset_req) begin
                rx_state_d[i]      = RX_ANA;
                rx_cnt_d[i]        = '0;
                relock_d[8*i +: 8] = 8'd0;
            end else if (!ch_enable[i]) begin
                rx_state_d[i] = RX_ANA;
                rx_cnt_d[i]   = '0;
            end else begin
                case (rx_state_q[i])
                    RX_ANA: begin
                        if (rx_cnt_q[i] == T_ANA_LAST) begin
                            rx_state_d[i] = RX_CAL;
                            rx_cnt_d[i]   = '0;
                        end else begin
                            rx_cnt_d[i]   = rx_cnt_q[i] + CNT_ONE;
                        end
                    end
                    RX_CAL: begin
                        rx_cnt_d[i] = '0;
                        if (!rx_cal_s[i]) begin
                            rx_state_d[i] = RX_LTD;
                        end else begin
                            rx_state_d[i] = RX_CAL;
                        end
                    end
                    RX_LTD: begin
                        if (!ltd_s[i]) begin
                            rx_cnt_d[i]   = '0;
                        end else if (rx_cnt_q[i] == T_LTD_LAST) begin
                            rx_state_d[i] = RX_BL;
                            rx_cnt_d[i]   = '0;
                        end else begin
                            rx_cnt_d[i]   = rx_cnt_q[i] + CNT_ONE;
                        end
                    end
                    RX_BL: begin
                        if (!ltd_s[i]) begin
                            rx_state_d[i] = RX_LTD;
                            rx_cnt_d[i]   = '0;
                        end else if (bl_s[i]) begin
                            rx_state_d[i] = RX_READY;
                            rx_cnt_d[i]   = '0;
                        end else if (rx_cnt_q[i] == T_BL_LAST) begin
                            rx_state_d[i]      = RX_ANA;
                            rx_cnt_d[i]        = '0;
                            relock_d[8*i +: 8] = sat_inc8(relock_q[8*i +: 8]);
                        end else begin
                            rx_cnt_d[i]   = rx_cnt_q[i] + CNT_ONE;
                        end
                    end
                    RX_READY: begin
                        rx_cnt_d[i] = '0;
                        // CDR loss outranks block-lock loss when both drop together.
                        if (!ltd_s[i]) begin
                            rx_state_d[i]      = RX_LTD;
                            relock_d[8*i +: 8] = sat_inc8(relock_q[8*i +: 8]);
                        end else if (!bl_s[i]) begin
                            rx_state_d[i]      = RX_BL;
                            relock_d[8*i +: 8] = sat_inc8(relock_q[8*i +: 8]);
                        end else begin
                            rx_state_d[i]      = RX_READY;
                        end
                    end
                    default: begin
                        rx_state_d[i] = RX_ANA;
                        rx_cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Output values decoded from next state so they register together with it.
    always_comb begin
        pd_d       = (tx_state_d == TX_PD);
        tx_ana_d   = ALL_ONES;
        tx_dig_d   = ALL_ONES;
        tx_ready_d = '0;
        if (tx_state_d == TX_PD) begin
            tx_ana_d = ALL_ONES;
        end else if (tx_state_d == TX_READY) begin
            tx_ana_d   = ~ch_enable;
            tx_dig_d   = ~ch_enable;
            tx_ready_d = ch_enable;
        end else begin
            tx_ana_d = ~ch_enable;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            rx_ana_d[i]   = (rx_state_d[i] == RX_ANA);
            rx_dig_d[i]   = !((rx_state_d[i] == RX_BL) || (rx_state_d[i] == RX_READY));
            rx_ready_d[i] = (rx_state_d[i] == RX_READY);
        end
        if (soft_reset_req) begin
            phy_ready_d = 1'b0;
        end else begin
            phy_ready_d = (|ch_enable) & (&(~ch_enable | (tx_ready_q & rx_ready_q)));
        end
    end

    // State, counter and registered-output flops.
    always_ff @(posedge csr_clk or negedge csr_rst_n) begin
        if (!csr_rst_n) begin
            tx_state_q  <= TX_PD;
            tx_cnt_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                rx_state_q[i] <= RX_ANA;
                rx_cnt_q[i]   <= '0;
            end
            relock_q    <= '0;
            pd_q        <= 1'b1;
            tx_ana_q    <= ALL_ONES;
            tx_dig_q    <= ALL_ONES;
            rx_ana_q    <= ALL_ONES;
            rx_dig_q    <= ALL_ONES;
            tx_ready_q  <= '0;
            rx_ready_q  <= '0;
            phy_ready_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            for (int i = 0; i < NUM_CH; i++) begin
                rx_state_q[i] <= rx_state_d[i];
                rx_cnt_q[i]   <= rx_cnt_d[i];
            end
            relock_q    <= relock_d;
            pd_q        <= pd_d;
            tx_ana_q    <= tx_ana_d;
            tx_dig_q    <= tx_dig_d;
            rx_ana_q    <= rx_ana_d;
            rx_dig_q    <= rx_dig_d;
            tx_ready_q  <= tx_ready_d;
            rx_ready_q  <= rx_ready_d;
            phy_ready_q <= phy_ready_d;
        end
    end

    assign pll_powerdown   = pd_q;
    assign tx_analogreset  = tx_ana_q;
    assign tx_digitalreset = tx_dig_q;
    assign rx_analogreset  = rx_ana_q;
    assign rx_digitalreset = rx_dig_q;
    assign tx_ready        = tx_ready_q;
    assign rx_ready        = rx_ready_q;
    assign phy_ready       = phy_ready_q;
    assign relock_count    = relock_q;

endmodule

// File: tb/tb_phy_rst_seq.sv
// Directed bench for phy_rst_seq (2 channels, short timings); cycle numbers count
// rising edges after reset release, and outputs are sampled 1 ns after each edge.
module tb_phy_rst_seq;

    logic        csr_clk;
    logic        csr_rst_n;
    logic        soft_reset_req;
    logic [1:0]  ch_enable;
    logic        pll_locked;
    logic [1:0]  tx_cal_busy;
    logic [1:0]  rx_cal_busy;
    logic [1:0]  rx_is_lockedtodata;
    logic [1:0]  block_lock;
    logic        pll_powerdown;
    logic [1:0]  tx_analogreset;
    logic [1:0]  tx_digitalreset;
    logic [1:0]  rx_analogreset;
    logic [1:0]  rx_digitalreset;
    logic [1:0]  tx_ready;
    logic [1:0]  rx_ready;
    logic        phy_ready;
    logic [15:0] relock_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    phy_rst_seq #(
        .NUM_CH(2), .CNT_W(20), .T_ANALOG(10), .T_DIGITAL(5), .T_LTD(20), .T_BL_TIMEOUT(100)
    ) dut (
        .csr_clk            (csr_clk),
        .csr_rst_n          (csr_rst_n),
        .soft_reset_req     (soft_reset_req),
        .ch_enable          (ch_enable),
        .pll_locked         (pll_locked),
        .tx_cal_busy        (tx_cal_busy),
        .rx_cal_busy        (rx_cal_busy),
        .rx_is_lockedtodata (rx_is_lockedtodata),
        .block_lock         (block_lock),
        .pll_powerdown      (pll_powerdown),
        .tx_analogreset     (tx_analogreset),
        .tx_digitalreset    (tx_digitalreset),
        .rx_analogreset     (rx_analogreset),
        .rx_digitalreset    (rx_digitalreset),
        .tx_ready           (tx_ready),
        .rx_ready           (rx_ready),
        .phy_ready          (phy_ready),
        .relock_count       (relock_count)
    );

    initial csr_clk = 1'b0;
    always #5 csr_clk = ~csr_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge csr_clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pd"},     pll_powerdown,   1'b1);
        chk({tag, "_txana"},  tx_analogreset,  2'b11);
        chk({tag, "_txdig"},  tx_digitalreset, 2'b11);
        chk({tag, "_rxana"},  rx_analogreset,  2'b11);
        chk({tag, "_rxdig"},  rx_digitalreset, 2'b11);
        chk({tag, "_txrdy"},  tx_ready,        2'b00);
        chk({tag, "_rxrdy"},  rx_ready,        2'b00);
        chk({tag, "_phy"},    phy_ready,       1'b0);
        chk({tag, "_relock"}, relock_count,    16'h0000);
    endtask

    initial begin
        csr_rst_n          = 1'b0;
        soft_reset_req     = 1'b0;
        ch_enable          = 2'b11;
        pll_locked         = 1'b1;
        tx_cal_busy        = 2'b00;
        rx_cal_busy        = 2'b00;
        rx_is_lockedtodata = 2'b11;
        block_lock         = 2'b11;
        repeat (3) @(posedge csr_clk);
        #1;
        chk_reset_vals("rst");
        csr_rst_n = 1'b1;
        cyc = 0;

        // Nominal bring-up
        run_to(9);   chk("pd_hi_9", pll_powerdown, 1'b1);
        run_to(10);  chk("pd_lo_10", pll_powerdown, 1'b0); chk("txana_10", tx_analogreset, 2'b00);
        run_to(15);  chk("txrdy_15", tx_ready, 2'b00);
        run_to(16);  chk("txrdy_16", tx_ready, 2'b11); chk("txdig_16", tx_digitalreset, 2'b00);
        run_to(30);  chk("rxdig_30", rx_digitalreset, 2'b11);
        run_to(31);  chk("rxdig_31", rx_digitalreset, 2'b00); chk("rxana_31", rx_analogreset, 2'b00);
        run_to(32);  chk("rxrdy_32", rx_ready, 2'b11); chk("phy_32", phy_ready, 1'b0);
        run_to(33);  chk("phy_33", phy_ready, 1'b1);

        // PLL loss and recovery in ready state
        run_to(40);  pll_locked = 1'b0;
        run_to(42);  chk("pll_txrdy_42", tx_ready, 2'b11);
        run_to(43);  chk("pll_txrdy_43", tx_ready, 2'b00); chk("pll_txdig_43", tx_digitalreset, 2'b11);
                     chk("pll_phy_43", phy_ready, 1'b1);
        run_to(44);  chk("pll_phy_44", phy_ready, 1'b0); pll_locked = 1'b1;
        run_to(51);  chk("pll_txrdy_51", tx_ready, 2'b00);
        run_to(52);  chk("pll_txrdy_52", tx_ready, 2'b11);
        run_to(53);  chk("pll_phy_53", phy_ready, 1'b1);

        // Channel disable
        run_to(60);  ch_enable = 2'b01;
        run_to(61);  chk("dis_rxrdy", rx_ready, 2'b01); chk("dis_txrdy", tx_ready, 2'b01);
                     chk("dis_rxana", rx_analogreset, 2'b10); chk("dis_rxdig", rx_digitalreset, 2'b10);
                     chk("dis_txana", tx_analogreset, 2'b10); chk("dis_txdig", tx_digitalreset, 2'b10);
        run_to(62);  chk("dis_phy_ch0", phy_ready, 1'b1);
        run_to(63);  ch_enable = 2'b00;
        run_to(64);  chk("dis_phy_none", phy_ready, 1'b0); chk("dis_rxrdy0", rx_ready, 2'b00);
                     chk("dis_txana0", tx_analogreset, 2'b11); chk("dis_pd0", pll_powerdown, 1'b0);
        run_to(66);  ch_enable = 2'b11;

        // Re-enable, with a one-cycle CDR glitch on channel 1 during RX_LTD
        run_to(67);  chk("en_txrdy_67", tx_ready, 2'b11); chk("en_rxana_67", rx_analogreset, 2'b11);
        run_to(76);  chk("en_rxana_76", rx_analogreset, 2'b00);
        run_to(80);  rx_is_lockedtodata = 2'b01;
        run_to(81);  rx_is_lockedtodata = 2'b11;
        run_to(97);  chk("gl_rxdig_97", rx_digitalreset, 2'b10);
        run_to(98);  chk("gl_rxrdy_98", rx_ready, 2'b01);
        run_to(102); chk("gl_rxdig_102", rx_digitalreset, 2'b10);
        run_to(103); chk("gl_rxdig_103", rx_digitalreset, 2'b00);
        run_to(104); chk("gl_rxrdy_104", rx_ready, 2'b11); chk("gl_phy_104", phy_ready, 1'b0);
        run_to(105); chk("gl_phy_105", phy_ready, 1'b1); block_lock = 2'b01;

        // Block-lock loss on channel 1 in RX_READY counts a relock
        run_to(107); chk("bl1_rxrdy_107", rx_ready, 2'b11); chk("bl1_relock_107", relock_count, 16'h0000);
        run_to(108); chk("bl1_rxrdy_108", rx_ready, 2'b01); chk("bl1_relock_108", relock_count, 16'h0100);
                     chk("bl1_rxdig_108", rx_digitalreset, 2'b00);
                     block_lock = 2'b10;

        // Soft reset coincides with channel 0 block-lock loss reaching the FSM
        run_to(110); chk("sr_rxrdy_110", rx_ready, 2'b01); soft_reset_req = 1'b1;
        run_to(111); soft_reset_req = 1'b0;
        chk_reset_vals("srst");
        run_to(120); chk("sr_pd_120", pll_powerdown, 1'b1);
        run_to(121); chk("sr_pd_121", pll_powerdown, 1'b0);
        run_to(126); chk("sr_txrdy_126", tx_ready, 2'b00);
        run_to(127); chk("sr_txrdy_127", tx_ready, 2'b11);
        run_to(141); chk("sr_rxdig_141", rx_digitalreset, 2'b11);
        run_to(142); chk("sr_rxdig_142", rx_digitalreset, 2'b00);
        run_to(143); chk("sr_rxrdy_143", rx_ready, 2'b10);
        run_to(144); chk("sr_phy_144", phy_ready, 1'b0);

        // Channel 0 block-lock watchdog: 131-cycle re-reset loop, saturating counter
        run_to(241);   chk("to_rxana_241", rx_analogreset, 2'b00); chk("to_relock_241", relock_count, 16'h0000);
        run_to(242);   chk("to_rxana_242", rx_analogreset, 2'b01); chk("to_relock_242", relock_count, 16'h0001);
                       chk("to_rxdig_242", rx_digitalreset, 2'b01);
        run_to(373);   chk("to_relock_373", relock_count, 16'h0002);
        run_to(33515); chk("to_relock_254", relock_count, 16'h00FE);
        run_to(33516); chk("to_relock_255", relock_count, 16'h00FF);
        run_to(39411); chk("to_relock_sat", relock_count, 16'h00FF); chk("to_rxana_end", rx_analogreset, 2'b01);
                       chk("to_phy_end", phy_ready, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phy_rst_seq.md
# phy_rst_seq

Parametrised multi-channel transceiver reset sequencer for the MAC/PHY subsystem, on the csr clock. It sequences a shared TX PLL and up to NUM_CH PHY channels through analog and digital reset release. It adds behaviour the single-channel reset controller lacks:
- per-channel enable
- RX block-lock watchdog with automatic re-reset
- relock event counters
- soft restart

## Interface
- NUM_CH, 1: channel count, 1..8.
- CNT_W, 20: width of every timing counter; all T_* values must be < 2^CNT_W.
- T_ANALOG, 100: cycles pll_powerdown and rx_analogreset are held asserted.
- T_DIGITAL, 20: cycles of stable TX lock / no calibration before tx_digitalreset release.
- T_LTD, 400: cycles rx_is_lockedtodata must stay continuously high before rx_digitalreset release.
- T_BL_TIMEOUT, 100000: cycles allowed from rx_digitalreset release to block_lock.
- csr_clk  in  1  sole clock.
- csr_rst_n  in  1  asynchronous, active-low reset.
- soft_reset_req  in  1  single-cycle synchronous restart pulse.
- ch_enable  in  NUM_CH  per-channel enable, quasi-static.
- pll_locked  in  1  TX PLL and core PLL lock, already ANDed, asynchronous.
- tx_cal_busy, rx_cal_busy  in  NUM_CH  calibration busy, asynchronous.
- rx_is_lockedtodata  in  NUM_CH  CDR lock, asynchronous.
- block_lock  in  NUM_CH  PCS block lock, asynchronous.
- pll_powerdown  out  1.
- tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset  out  NUM_CH.
- tx_ready, rx_ready  out  NUM_CH.
- phy_ready  out  1  all enabled channels have both tx_ready and rx_ready; 0 if no channel is enabled.
- relock_count  out  8*NUM_CH  per-channel saturating relock counter; channel i occupies [8i+7:8i].

## Operation
Input conditioning:
- All asynchronous status inputs pass through 2-flop synchronisers.
- FSMs act on the synchronised values only.

TX FSM, shared across channels:
- TX_PD: pll_powerdown=1; tx_analogreset=1 and tx_digitalreset=1 for all channels; count T_ANALOG cycles, then go to TX_WAIT.
- TX_WAIT: pll_powerdown=0; tx_analogreset=0 on enabled channels. Advance to TX_DIG when pll_locked=1 and tx_cal_busy=0 on every enabled channel.
- TX_DIG: count T_DIGITAL cycles. If the condition drops, return to TX_WAIT and clear the count. On completion go to TX_READY.
- TX_READY: tx_digitalreset=0 and tx_ready=1 on enabled channels. Loss of pll_locked → TX_WAIT, with tx_digitalreset=1 and tx_ready=0 on all channels.

RX FSM, one per channel:
- RX_ANA: rx_analogreset=1, rx_digitalreset=1; count T_ANALOG cycles, then go to RX_CAL.
- RX_CAL: rx_analogreset=0; wait for rx_cal_busy=0, then go to RX_LTD.
- RX_LTD: count while rx_is_lockedtodata=1; the count clears on any low cycle. Reaching T_LTD → RX_BL.
- RX_BL: rx_digitalreset=0; watchdog counts cycles.
  - block_lock=1 → RX_READY.
  - Watchdog reaches T_BL_TIMEOUT → RX_ANA, relock_count+1.
  - rx_is_lockedtodata=0 → RX_LTD, rx_digitalreset=1.
- RX_READY: rx_ready=1.
  - Loss of rx_is_lockedtodata → RX_LTD, rx_digitalreset=1, relock_count+1.
  - Loss of block_lock → RX_BL with the watchdog restarted, relock_count+1.
  - If both are lost in the same cycle, the rx_is_lockedtodata path wins.

Channel disable and soft reset:
- ch_enable[i]=0: channel i is forced to RX_ANA with its counter held at 0. All four of its resets are held at 1, its readies at 0, and it is excluded from the TX_WAIT condition and from phy_ready. relock_count[i] holds its value.
- Re-enable: channel i starts RX_ANA normally. Its TX outputs follow the current TX state.
- soft_reset_req=1: every FSM, counter and output returns to its reset value on the next edge, except relock_count, which is cleared. soft_reset_req takes priority over every simultaneous event.
- relock_count saturates at 255.

## Timing
- Reset values while csr_rst_n=0:
  - pll_powerdown=1.
  - All analog and digital resets = all ones.
  - tx_ready, rx_ready, phy_ready = 0.
  - relock_count = 0.
  - TX FSM in TX_PD; all RX FSMs in RX_ANA.
- All outputs are registered.
- First edge after reset release counts as cycle 1. pll_powerdown stays high for exactly T_ANALOG cycles.
- Input-to-FSM latency is 2 cycles for the synchronisers, and transitions take effect at the next edge. Loss of pll_locked is therefore visible on tx_ready 3 cycles after the raw input falls.
- phy_ready is registered one cycle after the per-channel readies.
- Counters compare against T_*−1 and reload to 0 on every state entry. Counters never wrap.

## Test plan
All scenarios use NUM_CH=2, T_ANALOG=10, T_DIGITAL=5, T_LTD=20, T_BL_TIMEOUT=100.

- Nominal bring-up: release reset with all status inputs good → pll_powerdown falls at cycle 10; tx_ready=2'b11; rx_ready=2'b11 after block_lock; phy_ready=1.
- CDR glitch: drop rx_is_lockedtodata[1] for 1 cycle during RX_LTD → channel 1's T_LTD count restarts; rx_digitalreset[1] releases 20 cycles after the input recovers.
- Block-lock timeout: hold block_lock[0]=0 → after 100 cycles in RX_BL, rx_analogreset[0] reasserts and relock_count[7:0]=1. Repeat 300 times → relock_count[7:0] saturates at 255.
- PLL loss in ready state: drop pll_locked → tx_ready=0 and phy_ready=0 with the specified latency. Restore pll_locked → tx_ready returns 5 cycles after the synchronised condition holds.
- Channel disable: ch_enable=2'b01 → channel 1 resets stay 1 and rx_ready[1]=0, while phy_ready=1 from channel 0 alone. With ch_enable=2'b00, phy_ready=0.
- Soft reset mid-operation: pulse soft_reset_req in RX_READY, in the same cycle as a block_lock loss → all outputs return to reset values on the next edge, relock_count=0, and the full sequence replays.
